// File: rtl/load_sequencer_pkg.sv
// Shared types for the load/run/dump sequencer: session states and the
// processor-mode encodings driven on the status port.
package load_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_ADDR,
        DUMP_WAIT,
        DUMP_OUT,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] ST_HOLD  = 2'b00;
    localparam logic [1:0] ST_WRITE = 2'b10;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_READ  = 2'b11;

endpackage

// File: rtl/ls_byte_counter.sv
// 16-bit index counter shared by the load and dump phases: synchronous clear,
// increment, and a terminal-count flag against a caller-supplied last index.
module ls_byte_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        inc_i,
    input  logic [15:0] last_i,
    output logic [15:0] count_o,
    output logic        tc_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 16'h0000;
        end else if (inc_i) begin
            count_d = count_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/load_sequencer.sv
// Load/run/dump session sequencer: streams program bytes into data memory,
// lets the processor run, then streams a memory window back out.
// Optional RUN watchdog with err output when LOAD_SEQUENCER_TIMEOUT_EN is defined.
module load_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int unsigned LOAD_LEN  = 16,
    parameter logic [15:0] DUMP_BASE = 16'h0000,
    parameter int unsigned DUMP_LEN  = 16,
    parameter int unsigned RD_LAT    = 2
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
    ,
    parameter int unsigned RUN_TIMEOUT = 1_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        end_process,
    input  logic [7:0]  dm_out,
    output logic [1:0]  status,
    output logic [7:0]  data_in,
    output logic [15:0] data_addr_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    state_e      state_q, state_d;
    logic [1:0]  status_q, status_d;
    logic [7:0]  data_in_q, data_in_d;
    logic [15:0] addr_q, addr_d;
    logic        in_ready_q, in_ready_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] wait_q, wait_d;
    logic        cnt_clr, cnt_inc, cnt_tc;
    logic [15:0] cnt_last, cnt;
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
    logic [23:0] run_cnt_q, run_cnt_d;
    logic        err_q, err_d;
`endif

    ls_byte_counter u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .last_i  (cnt_last),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        data_in_d   = data_in_q;
        addr_d      = addr_q;
        in_ready_d  = in_ready_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        wait_d      = wait_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        cnt_last    = (state_q == LOAD) ? 16'(LOAD_LEN - 1) : 16'(DUMP_LEN - 1);
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
        run_cnt_d   = run_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LOAD;
                    status_d   = ST_HOLD;
                    cnt_clr    = 1'b1;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                end
            end
            LOAD: begin
                // Each accepted byte becomes a single-cycle write pulse next cycle.
                status_d = ST_HOLD;
                if (in_valid && in_ready_q) begin
                    status_d  = ST_WRITE;
                    data_in_d = in_data;
                    addr_d    = cnt;
                    cnt_inc   = 1'b1;
                    if (cnt_tc) begin
                        in_ready_d = 1'b0;
                        state_d    = RUN;
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
                        run_cnt_d  = 24'h000000;
`endif
                    end
                end
            end
            RUN: begin
                status_d = ST_RUN;
                if (end_process) begin
                    status_d = ST_HOLD;
                    state_d  = DUMP_ADDR;
                    cnt_clr  = 1'b1;
                end
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
                else if (run_cnt_q == 24'(RUN_TIMEOUT - 1)) begin
                    status_d = ST_HOLD;
                    state_d  = ERR;
                    busy_d   = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    run_cnt_d = run_cnt_q + 24'h000001;
                end
`endif
            end
            DUMP_ADDR: begin
                status_d = ST_READ;
                addr_d   = DUMP_BASE + cnt;
                wait_d   = 16'h0000;
                state_d  = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                if (wait_q == 16'(RD_LAT - 1)) begin
                    state_d = DUMP_OUT;
                end else begin
                    wait_d = wait_q + 16'h0001;
                end
            end
            DUMP_OUT: begin
                // One capture cycle after the wait so dm_out has fully settled.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = dm_out;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_inc     = 1'b1;
                    if (cnt_tc) begin
                        state_d  = DONE;
                        status_d = ST_HOLD;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        state_d = DUMP_ADDR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            status_q    <= ST_HOLD;
            data_in_q   <= 8'h00;
            addr_q      <= 16'h0000;
            in_ready_q  <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wait_q      <= 16'h0000;
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
            run_cnt_q   <= 24'h000000;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            data_in_q   <= data_in_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wait_q      <= wait_d;
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
            run_cnt_q   <= run_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign status       = status_q;
    assign data_in      = data_in_q;
    assign data_addr_in = addr_q;
    assign in_ready     = in_ready_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
`ifdef LOAD_SEQUENCER_TIMEOUT_EN
    assign err          = err_q;
`endif

endmodule
